// File: rtl/core_pkg.sv
// Shared types and constants for the MIPS32 core control path.
package core_pkg;

    // Occupancy state of the HI/LO multiply/divide unit.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state;

    // Architectural $zero: writes to it never create a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mult/div occupancy in cycles, counted from the start pulse.
    localparam int MD_LATENCY_DEF = 32;

    // Countdown width; covers the full legal latency range up to 63.
    localparam int MD_CNT_W = 6;

endpackage

// File: rtl/md_scoreboard.sv
// Tracks occupancy of the HI/LO mult/div unit: a two-state FSM with a
// countdown loaded on the start pulse. busy_o is registered and is high
// for MD_LATENCY-1 cycles, starting the cycle after start_i.
module md_scoreboard
    import core_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic start_i,
    output logic busy_o
);

    md_state               state_q;
    logic [MD_CNT_W-1:0]   cnt_q;
    logic                  busy_q;

    // FSM with countdown; busy is registered alongside the state so it
    // drops on the same edge that returns the unit to idle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q <= MD_RUN;
                        cnt_q   <= MD_CNT_W'(MD_LATENCY - 1);
                        busy_q  <= 1'b1;
                    end
                end
                MD_RUN: begin
                    // The edge that brings the count to zero also ends the
                    // busy window, so a dependent instruction issues in the
                    // MD_LATENCY-th cycle after start.
                    cnt_q <= cnt_q - MD_CNT_W'(1);
                    if (cnt_q <= MD_CNT_W'(1)) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: resolves load-use hazards,
// HI/LO occupancy hazards, taken branches and jumps, and drives the front
// end enables/flushes. Also counts front-end stall cycles (saturating).
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_RsAddr,
    input  logic [4:0]       ID_RtAddr,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsMulDiv,
    input  logic             ID_ReadsHiLo,
    input  logic             ID_Jump,
    input  logic             ID_EX_MemRd,
    input  logic [4:0]       ID_EX_RegWrAddr,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MD_Start,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] StallCount
);

    logic             md_busy_raw;
    logic             busy_eff;
    logic             lu_hazard;
    logic             hl_hazard;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    md_scoreboard #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_scoreboard (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (MD_Start),
        .busy_o  (md_busy_raw)
    );

    // While reset is held the unit is treated as free, so the hazard
    // equations see MD_Busy=0 even before the first reset edge.
    assign busy_eff = md_busy_raw & rst_n;

    // Hazard detection, stall/flush resolution and mult/div issue.
    always_comb begin
        lu_hazard = ID_EX_MemRd && (ID_EX_RegWrAddr != REG_ZERO) &&
                    ((ID_UsesRs && (ID_RsAddr == ID_EX_RegWrAddr)) ||
                     (ID_UsesRt && (ID_RtAddr == ID_EX_RegWrAddr)));
        hl_hazard = busy_eff && (ID_IsMulDiv || ID_ReadsHiLo);
        // A taken branch squashes the stalled instruction, so it wins.
        stall     = (lu_hazard || hl_hazard) && !EX_BranchTaken;

        PC_Write    = !stall;
        IF_ID_Write = !stall;
        // A stalled jump keeps its flush until the cycle it issues.
        IF_ID_Flush = EX_BranchTaken || (ID_Jump && !stall);
        ID_EX_Flush = stall || EX_BranchTaken;
        MD_Start    = ID_IsMulDiv && !stall && !EX_BranchTaken;
        MD_Busy     = busy_eff;
    end

    // Saturating next value of the stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int LAT    = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    ID_RsAddr, ID_RtAddr, ID_EX_RegWrAddr;
    logic          ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo, ID_Jump;
    logic          ID_EX_MemRd, EX_BranchTaken;
    logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic          MD_Start, MD_Busy;
    logic [CW-1:0] StallCount;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: remaining busy cycles of the HI/LO unit and the
    // saturating stall count.
    int   m_rem = 0;
    int   m_cnt = 0;
    logic e_pcw, e_ifw, e_iff, e_exf, e_start, e_busy;

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
        .ID_Jump(ID_Jump), .ID_EX_MemRd(ID_EX_MemRd),
        .ID_EX_RegWrAddr(ID_EX_RegWrAddr), .EX_BranchTaken(EX_BranchTaken),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MD_Start(MD_Start), .MD_Busy(MD_Busy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ID_RsAddr = 5'd0; ID_RtAddr = 5'd0; ID_EX_RegWrAddr = 5'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_IsMulDiv = 1'b0;
        ID_ReadsHiLo = 1'b0; ID_Jump = 1'b0; ID_EX_MemRd = 1'b0;
        EX_BranchTaken = 1'b0;
    endtask

    task automatic drive_load_use();
        ID_EX_MemRd = 1'b1; ID_EX_RegWrAddr = 5'd8;
        ID_UsesRs = 1'b1; ID_RsAddr = 5'd8;
    endtask

    task automatic model_eval();
        logic lu, hl, st;
        lu = ID_EX_MemRd && (ID_EX_RegWrAddr != 5'd0) &&
             ((ID_UsesRs && ID_RsAddr == ID_EX_RegWrAddr) ||
              (ID_UsesRt && ID_RtAddr == ID_EX_RegWrAddr));
        e_busy  = rst_n && (m_rem > 0);
        hl      = e_busy && (ID_IsMulDiv || ID_ReadsHiLo);
        st      = (lu || hl) && !EX_BranchTaken;
        e_pcw   = !st;
        e_ifw   = !st;
        e_iff   = EX_BranchTaken || (ID_Jump && !st);
        e_exf   = st || EX_BranchTaken;
        e_start = ID_IsMulDiv && !st && !EX_BranchTaken;
    endtask

    // Update the model with the current inputs, then move one clock on.
    task automatic advance();
        model_eval();
        if (!rst_n) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (!e_pcw && m_cnt < CNTMAX) m_cnt++;
            if (m_rem > 0) m_rem--;
            else if (e_start) m_rem = LAT - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (StallCount !== 4'd0 || MD_Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: StallCount=%0d MD_Busy=%b, want 0 0", StallCount, MD_Busy);
        end
        tests_run++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start} !== 5'b11000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 11000",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_load_use();
        #1;
        tests_run++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush} !== 3'b001) begin
            fails++;
            $display("FAIL load_use_stall: PC_W/IFID_W/IDEX_F=%b want 001",
                     {PC_Write, IF_ID_Write, ID_EX_Flush});
        end
        advance();
        idle_inputs();
        #1;
        tests_run++;
        if (PC_Write !== 1'b1 || StallCount !== 4'd1) begin
            fails++;
            $display("FAIL load_use_release: PC_Write=%b StallCount=%0d want 1 1", PC_Write, StallCount);
        end
    endtask

    task automatic test_load_zero();
        do_reset();
        ID_EX_MemRd = 1'b1; ID_EX_RegWrAddr = 5'd0; ID_UsesRs = 1'b1; ID_RsAddr = 5'd0;
        #1;
        tests_run++;
        if (PC_Write !== 1'b1 || ID_EX_Flush !== 1'b0) begin
            fails++;
            $display("FAIL load_zero: PC_Write=%b ID_EX_Flush=%b want 1 0", PC_Write, ID_EX_Flush);
        end
    endtask

    task automatic test_mult_mfhi();
        int stalls;
        do_reset();
        ID_IsMulDiv = 1'b1;
        #1;
        tests_run++;
        if (MD_Start !== 1'b1 || MD_Busy !== 1'b0) begin
            fails++;
            $display("FAIL mult_start: MD_Start=%b MD_Busy=%b want 1 0", MD_Start, MD_Busy);
        end
        advance();
        idle_inputs();
        ID_ReadsHiLo = 1'b1;
        stalls = 0;
        for (int i = 0; i < LAT - 1; i++) begin
            #1;
            if (MD_Busy === 1'b1 && PC_Write === 1'b0) stalls++;
            advance();
        end
        tests_run++;
        if (stalls != LAT - 1) begin
            fails++;
            $display("FAIL mfhi_stalls: busy stall cycles=%0d want %0d", stalls, LAT - 1);
        end
        #1;
        tests_run++;
        if (MD_Busy !== 1'b0 || PC_Write !== 1'b1 || StallCount !== 4'(LAT - 1)) begin
            fails++;
            $display("FAIL mfhi_release: MD_Busy=%b PC_Write=%b StallCount=%0d want 0 1 %0d",
                     MD_Busy, PC_Write, StallCount, LAT - 1);
        end
    endtask

    task automatic test_back_to_back();
        int wait_cycles;
        do_reset();
        ID_IsMulDiv = 1'b1;
        advance();
        wait_cycles = 0;
        #1;
        while (MD_Start !== 1'b1 && wait_cycles < 20) begin
            advance();
            wait_cycles++;
        end
        tests_run++;
        if (wait_cycles != LAT - 1) begin
            fails++;
            $display("FAIL back_to_back: second start after %0d stall cycles want %0d", wait_cycles, LAT - 1);
        end
        idle_inputs();
    endtask

    task automatic test_branch_over_stall();
        do_reset();
        drive_load_use();
        EX_BranchTaken = 1'b1;
        ID_IsMulDiv = 1'b1;
        #1;
        tests_run++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start} !== 5'b11110) begin
            fails++;
            $display("FAIL branch_override: got %b want 11110",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start});
        end
        advance();
        idle_inputs();
        #1;
        tests_run++;
        if (StallCount !== 4'd0 || MD_Busy !== 1'b0) begin
            fails++;
            $display("FAIL branch_no_count: StallCount=%0d MD_Busy=%b want 0 0", StallCount, MD_Busy);
        end
    endtask

    task automatic test_jump_stall();
        do_reset();
        drive_load_use();
        ID_Jump = 1'b1;
        #1;
        tests_run++;
        if (IF_ID_Flush !== 1'b0 || PC_Write !== 1'b0) begin
            fails++;
            $display("FAIL jump_stalled: IF_ID_Flush=%b PC_Write=%b want 0 0", IF_ID_Flush, PC_Write);
        end
        advance();
        ID_EX_MemRd = 1'b0;
        #1;
        tests_run++;
        if (IF_ID_Flush !== 1'b1 || ID_EX_Flush !== 1'b0) begin
            fails++;
            $display("FAIL jump_issue: IF_ID_Flush=%b ID_EX_Flush=%b want 1 0", IF_ID_Flush, ID_EX_Flush);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        ID_IsMulDiv = 1'b1;
        advance();
        idle_inputs();
        advance();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (MD_Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_mask: MD_Busy=%b want 0", MD_Busy);
        end
        advance();
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (MD_Busy !== 1'b0 || StallCount !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_run: MD_Busy=%b StallCount=%0d want 0 0", MD_Busy, StallCount);
        end
        ID_ReadsHiLo = 1'b1;
        #1;
        tests_run++;
        if (PC_Write !== 1'b1) begin
            fails++;
            $display("FAIL reset_abandon: PC_Write=%b want 1", PC_Write);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_load_use();
        for (int i = 0; i < 20; i++) advance();
        tests_run++;
        if (StallCount !== 4'd15) begin
            fails++;
            $display("FAIL stall_saturate: StallCount=%0d want 15", StallCount);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ID_RsAddr       = 5'($urandom_range(0, 3));
            ID_RtAddr       = 5'($urandom_range(0, 3));
            ID_EX_RegWrAddr = 5'($urandom_range(0, 3));
            ID_UsesRs       = 1'($urandom_range(0, 1));
            ID_UsesRt       = 1'($urandom_range(0, 1));
            ID_EX_MemRd     = ($urandom_range(0, 2) == 0);
            ID_IsMulDiv     = ($urandom_range(0, 4) == 0);
            ID_ReadsHiLo    = ($urandom_range(0, 3) == 0);
            ID_Jump         = ($urandom_range(0, 5) == 0);
            EX_BranchTaken  = ($urandom_range(0, 7) == 0);
            rst_n           = ($urandom_range(0, 60) != 0);
            #1;
            model_eval();
            tests_run++;
            if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy} !==
                {e_pcw, e_ifw, e_iff, e_exf, e_start, e_busy} || StallCount !== 4'(m_cnt)) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d: outs=%b cnt=%0d want outs=%b cnt=%0d", cyc,
                             {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy},
                             StallCount, {e_pcw, e_ifw, e_iff, e_exf, e_start, e_busy}, m_cnt);
                bad++;
            end
            advance();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_load_zero();
        test_mult_mfhi();
        test_back_to_back();
        test_branch_over_stall();
        test_jump_stall();
        test_reset_mid_run();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
